// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte/column helpers for the iterative round core.
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal,
    StDone
  } aes_fsm_e;

  // Forward S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b111} -: 8];
  endfunction

  // Byte i of a 128-bit block, byte 0 at [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
    return s[{~i, 3'b111} -: 8];
  endfunction

  // Column c of a 128-bit block, column 0 at [127:96].
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    return s[{~c, 5'b11111} -: 32];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round; i_final bypasses MixColumns for the last round.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_final,
  output logic [127:0] o_state
);

  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;

  always_comb begin
    w_sub = '0;
    for (int i = 0; i < 16; i++) begin
      w_sub[127 - 8*i -: 8] = sbox(get_byte(i_state, 4'(i)));
    end
  end

  // Row r of column c takes row r of column (c + r) mod 4.
  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[127 - 8*(4*c + r) -: 8] = get_byte(w_sub, 4'(4*((c + r) % 4) + r));
      end
    end
  end

  mix_columns u_mix_columns (
    .i_state(w_shift),
    .o_state(w_mix)
  );

  assign o_state = (i_final ? w_shift : w_mix) ^ i_round_key;

endmodule

// File: rtl/mix_columns.sv
// MixColumns over all four 32-bit columns of the AES state.
module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign o_state = {mix_col(get_col(i_state, 2'd0)), mix_col(get_col(i_state, 2'd1)),
                    mix_col(get_col(i_state, 2'd2)), mix_col(get_col(i_state, 2'd3))};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption controller: one round per clock over a single 128-bit state register,
// valid/ready on both sides, round keys fetched combinationally by index from an external store.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR       = NR_128,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        round_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  localparam logic [RK_IDX_W-1:0] LastRound = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] FinalIdx  = RK_IDX_W'(NR);

  aes_fsm_e              r_fsm;
  logic [RK_IDX_W-1:0]   r_round;
  logic [127:0]          r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [127:0]          w_next;

  aes_round u_aes_round (
    .i_state    (r_state),
    .i_round_key(round_key),
    .i_final    (r_fsm == StFinal),
    .o_state    (w_next)
  );

  always_comb begin
    rk_idx = '0;
    unique case (r_fsm)
      StRound: rk_idx = r_round;
      StFinal: rk_idx = FinalIdx;
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= StIdle;
      r_round     <= '0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_fsm)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_state    <= data_in ^ round_key;
            r_round    <= RK_IDX_W'(1);
            r_fsm      <= StRound;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StRound: begin
          r_state <= w_next;
          r_round <= r_round + RK_IDX_W'(1);
          if (r_round == LastRound) r_fsm <= StFinal;
        end
        StFinal: begin
          r_state     <= w_next;
          r_fsm       <= StDone;
          r_out_valid <= 1'b1;
        end
        StDone: begin
          // No bypass to a new accept: in_ready returns only after the handshake edge.
          if (out_ready) begin
            r_fsm       <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_fsm <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign data_out  = r_state;

endmodule
